tc_sram_stream_adapter: RTL and testbench

// - Upstream front-end for a single-port generic SRAM macro with fixed read latency.
// - Converts a valid/ready request stream into the SRAM's req/we/addr/wdata/be strobes.
// - Tracks reads through a Latency-deep pipeline and buffers read data in a response FIFO.
// - Credit check guarantees no response is ever lost under downstream back-pressure.

---
 rtl/tc_sram_adapter_pkg.sv | 28 ++
 rtl/tc_sram_resp_fifo.sv | 64 ++++++
 rtl/tc_sram_stream_adapter.sv | 129 ++++++++++++
 tb/tb_tc_sram_stream_adapter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sram_adapter_pkg.sv
// Shared types and width helpers for the SRAM stream adapter.
//   pipe_entry_t    : one read-pipeline stage {resp_needed, err}
//   calc_addr_width : SRAM address width for a given word count (min 1)
//   calc_be_width   : byte-enable width, ceil(data_width / byte_width)
//   calc_cnt_width  : width of a counter that must reach 'depth'
// The response record resp_t {rdata, err} depends on DataWidth, so it is
// declared inside the adapter and handed to the FIFO as a type parameter.
package tc_sram_adapter_pkg;

  typedef struct packed {
    logic resp_needed;
    logic err;
  } pipe_entry_t;

  function automatic int unsigned calc_addr_width(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  function automatic int unsigned calc_be_width(input int unsigned data_width,
                                                input int unsigned byte_width);
    return (data_width + byte_width - 1) / byte_width;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tc_sram_resp_fifo.sv
// Synchronous-reset, first-word-visible FIFO holding adapter responses.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, empties the FIFO
//   push_i  : write data_i (ignored when full and not popping)
//   data_i  : entry to write
//   pop_i   : drop the head entry (ignored when empty)
//   data_o  : head entry, valid whenever empty_o is low
//   empty_o : no entries stored
//   full_o  : Depth entries stored
//   count_o : number of stored entries
import tc_sram_adapter_pkg::*;

module tc_sram_resp_fifo #(
  parameter int unsigned Depth   = 3,
  parameter type         entry_t = logic,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = calc_cnt_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  entry_t              data_i,
  input  logic                pop_i,
  output entry_t              data_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [CntWidth-1:0] count_o
);

  entry_t              mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                do_push, do_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntWidth'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tc_sram_stream_adapter.sv
// Valid/ready front-end for a single-port SRAM with fixed read latency.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   req_valid_i/req_ready_o : request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_be_i : request payload
//   resp_valid_o/resp_ready_i, resp_rdata_o, resp_err_o : in-order responses
//   sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o : SRAM strobes
//   sram_rdata_i            : SRAM read data, Latency cycles after a read
// Build option: TC_SRAM_ADAPTER_WRITE_RESP_EN makes every write return a
// response (rdata 0); otherwise writes return nothing.
import tc_sram_adapter_pkg::*;

module tc_sram_stream_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RespDepth = Latency + 2,
  localparam int unsigned AddrWidth = calc_addr_width(NumWords),
  localparam int unsigned BeWidth   = calc_be_width(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = calc_cnt_width(RespDepth);
  localparam logic [AddrWidth:0] NumWordsExt = (AddrWidth + 1)'(NumWords);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } resp_t;

  pipe_entry_t         pipe_q [Latency];
  logic [Latency-1:0]  rd_q;       // stage carries an in-range read: take SRAM data
  logic [CntWidth-1:0] inflight_q, fifo_cnt;
  logic [CntWidth:0]   credit_used;
  logic                acc, in_range, resp_needed, inc, push, pop;
  logic                fifo_empty, fifo_full;
  resp_t               push_data, pop_data;

  // Credit only from registered counters, so ready never depends on inputs.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign req_ready_o = ~rst_i & (credit_used < (CntWidth + 1)'(RespDepth));
  assign acc         = req_valid_i & req_ready_o;
  assign in_range    = ({1'b0, req_addr_i} < NumWordsExt);

`ifdef TC_SRAM_ADAPTER_WRITE_RESP_EN
  assign resp_needed = 1'b1;
`else
  assign resp_needed = ~req_we_i;
`endif

  assign sram_req_o   = acc & in_range;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Latency; i++) pipe_q[i] <= '0;
      rd_q <= '0;
    end else begin
      pipe_q[0] <= '{resp_needed: acc & resp_needed, err: ~in_range};
      rd_q[0]   <= acc & ~req_we_i & in_range;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
        rd_q[i]   <= rd_q[i-1];
      end
    end
  end

  assign push            = pipe_q[Latency-1].resp_needed;
  assign push_data.rdata = rd_q[Latency-1] ? sram_rdata_i : '0;
  assign push_data.err   = pipe_q[Latency-1].err;

  assign inc = acc & resp_needed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else if (inc && !push) begin
      inflight_q <= inflight_q + CntWidth'(1);
    end else if (!inc && push) begin
      inflight_q <= inflight_q - CntWidth'(1);
    end
  end

  assign resp_valid_o = ~fifo_empty & ~rst_i;
  assign pop          = resp_valid_o & resp_ready_i;
  assign resp_rdata_o = pop_data.rdata;
  assign resp_err_o   = pop_data.err;

  tc_sram_resp_fifo #(
    .Depth   (RespDepth),
    .entry_t (resp_t)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (pop_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  // Credit accounting makes this unreachable; a hit means the counters drifted.
  resp_fifo_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full));

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Self-checking bench for tc_sram_stream_adapter with a behavioural SRAM.
module tb_tc_sram_stream_adapter;

  localparam int unsigned NW  = 1000;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned RD  = 4;
  localparam int unsigned AW  = 10;
  localparam int unsigned BEW = 4;
`ifdef TC_SRAM_ADAPTER_WRITE_RESP_EN
  localparam bit WR_RESP = 1'b1;
`else
  localparam bit WR_RESP = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_valid_i, req_ready_o, req_we_i;
  logic [AW-1:0]  req_addr_i;
  logic [DW-1:0]  req_wdata_i;
  logic [BEW-1:0] req_be_i;
  logic           resp_valid_o, resp_ready_i, resp_err_o;
  logic [DW-1:0]  resp_rdata_o;
  logic           sram_req_o, sram_we_o;
  logic [AW-1:0]  sram_addr_o;
  logic [DW-1:0]  sram_wdata_o, sram_rdata_i;
  logic [BEW-1:0] sram_be_o;

  always #5 clk_i = ~clk_i;

  tc_sram_stream_adapter #(
    .NumWords  (NW),
    .DataWidth (DW),
    .ByteWidth (8),
    .Latency   (LAT),
    .RespDepth (RD)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_be_o    (sram_be_o),
    .sram_rdata_i (sram_rdata_i)
  );

  // Generic SRAM: byte-masked write, read data LAT cycles after the request.
  // Idle cycles present a junk pattern so unmasked data paths show up.
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk_i) begin
    if (sram_req_o && sram_we_o)
      for (int b = 0; b < BEW; b++)
        if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
    rd_pipe[0] <= (sram_req_o && !sram_we_o) ? mem[sram_addr_o] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata_i = rd_pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_s;

  typedef struct {
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [BEW-1:0] be;
    logic [DW-1:0]  exp_rdata;
    logic           exp_err;
  } vec_t;

  resp_s exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    resp_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk_i) begin
    resp_s e;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      check("sram_req", sram_req_o,
            req_valid_i & req_ready_o & (32'(req_addr_i) < NW));
      if (resp_valid_o && resp_ready_i) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata 0x%0h err %0b, expected none (t=%0t)",
                   resp_rdata_o, resp_err_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata_o, e.rdata);
          check("resp_err", resp_err_o, e.err);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [BEW-1:0] be, input logic [DW-1:0] exp_rdata,
                      input logic exp_err);
    bit done = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        done = 1'b1;
        if (!we || WR_RESP) exp_q.push_back('{exp_rdata, exp_err});
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      @(posedge clk_i);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    logic [AW-1:0] bp_addr[4];
    logic [DW-1:0] bp_data[4];
    int k, lat, seen0;

    vecs[0]  = '{1'b1, 10'd5,    32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 10'd5,    32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 10'd6,    32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 10'd6,    32'h11223344, 4'h3, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 10'd6,    32'h0,        4'h0, 32'hA5A53344, 1'b0};
    vecs[5]  = '{1'b0, 10'd1010, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 10'd999,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 10'd999,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, 10'd1000, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 10'd1005, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 10'd0,    32'h01020304, 4'hF, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 10'd0,    32'hFFFFFFFF, 4'h8, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 10'd0,    32'h0,        4'h0, 32'hFF020304, 1'b0};
    bp_addr = '{10'd5, 10'd6, 10'd999, 10'd0};
    bp_data = '{32'hDEADBEEF, 32'hA5A53344, 32'hCAFEF00D, 32'hFF020304};

    // Reset held 3 cycles while a request is offered.
    rst_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 10'd1010;
    req_wdata_i = '0; req_be_i = '0; resp_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("rst_req_ready", req_ready_o, 1'b0);
      check("rst_sram_req", sram_req_o, 1'b0);
      check("rst_resp_valid", resp_valid_o, 1'b0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_rst", req_ready_o, 1'b1);
    if (req_ready_o) exp_q.push_back('{32'h0, 1'b1});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    drain("drain_after_rst");

    // Vector table.
    for (int unsigned i = 0; i < 13; i++)
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
           vecs[i].exp_rdata, vecs[i].exp_err);
    drain("drain_table");

    // Read latency: valid LAT cycles after accept plus one FIFO cycle.
    send(1'b0, 10'd5, '0, '0, 32'hDEADBEEF, 1'b0);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!resp_valid_o && lat < 20);
    check("read_latency", lat, LAT + 1);
    @(posedge clk_i); #1;
    drain("drain_latency");

    // Back-pressure: responses stalled, only RD requests may be accepted.
    resp_ready_i = 1'b0; k = 0;
    req_valid_i = 1'b1; req_we_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_addr_i = bp_addr[k % 4];
      @(negedge clk_i);
      if (req_ready_o) begin
        exp_q.push_back('{bp_data[k % 4], 1'b0});
        k++;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    check("bp_accepted", k, RD);
    check("bp_ready_low", req_ready_o, 1'b0);
    check("bp_resp_valid", resp_valid_o, 1'b1);
    resp_ready_i = 1'b1;
    drain("drain_bp");
    check("bp_ready_back", req_ready_o, 1'b1);

    // Sustained throughput: one read accepted every cycle.
    k = 0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 10'd999;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        exp_q.push_back('{32'hCAFEF00D, 1'b0});
        k++;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    check("throughput_accepts", k, 8);
    drain("drain_throughput");

    // Reset with three reads in flight: nothing stale may come out.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 10'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (req_ready_o) exp_q.push_back('{32'hDEADBEEF, 1'b0});
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    seen0 = resp_seen;
    repeat (8) begin
      @(posedge clk_i); #1;
    end
    check("no_stale_resp", resp_seen - seen0, 0);
    send(1'b0, 10'd999, '0, '0, 32'hCAFEF00D, 1'b0);
    drain("drain_after_midrst");

    // Two writes and a read: write responses only with the build option.
    seen0 = resp_seen;
    send(1'b1, 10'd10, 32'h11111111, 4'hF, 32'h0, 1'b0);
    send(1'b1, 10'd11, 32'h22222222, 4'hF, 32'h0, 1'b0);
    send(1'b0, 10'd10, '0, '0, 32'h11111111, 1'b0);
    drain("drain_macro");
    check("macro_resp_count", resp_seen - seen0, WR_RESP ? 3 : 1);

    repeat (4) @(posedge clk_i);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
